// File: rtl/test_monitor_pkg.sv
// Shared types and default addresses/codes for the end-of-test monitor.
package test_monitor_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PASS = 2'd1,
        FAIL = 2'd2,
        TMO  = 2'd3
    } state_e;

    localparam logic [31:0] FINISH_ADDR_DEF = 32'h4000_8000;
    localparam logic [31:0] PASS_CODE_DEF   = 32'h0000_0777;
    localparam logic [31:0] CON_ADDR_DEF    = 32'h4000_8004;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read port; a push into a full
// FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full_o     = (r_count == (AW+1)'(DEPTH));
    assign empty_o    = (r_count == '0);
    assign w_pop      = pop_i && !empty_o && !clr_i;
    assign w_push     = push_i && !clr_i && (!full_o || w_pop);
    assign pop_data_o = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; clr_i flushes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
            r_rd_ptr <= w_pop  ? r_rd_ptr + AW'(1) : r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

endmodule

// File: rtl/test_monitor.sv
// End-of-test monitor: decodes finish-register writes into pass/fail/timeout.
// Optional console FIFO enabled by macro TEST_MONITOR_CONSOLE_EN.
module test_monitor
    import test_monitor_pkg::*;
#(
    parameter int                NUM_CH         = 1,
    parameter int                ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] FINISH_ADDR    = ADDR_W'(FINISH_ADDR_DEF),
    parameter logic [31:0]       PASS_CODE      = PASS_CODE_DEF,
    parameter int                TIMEOUT_CYCLES = 0,
    parameter logic [ADDR_W-1:0] CON_ADDR       = ADDR_W'(CON_ADDR_DEF),
    parameter int                CON_DEPTH      = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic [NUM_CH*4-1:0]      wr_en_i,
    input  logic [NUM_CH*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_CH*32-1:0]     wr_data_i,
`ifdef TEST_MONITOR_CONSOLE_EN
    input  logic                     con_ready_i,
    output logic                     con_valid_o,
    output logic [7:0]               con_data_o,
    output logic                     con_drop_o,
`endif
    output logic [63:0]              cycle_o,
    output logic [NUM_CH-1:0]        ch_done_o,
    output logic                     done_o,
    output logic                     pass_o,
    output logic                     fail_o,
    output logic                     timeout_o,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] fail_ch_o,
    output logic [31:0]              fail_code_o
);
    localparam int          FCW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [63:0] TMO_LAST = TMO_EN ? 64'(TIMEOUT_CYCLES - 1) : 64'd0;

    state_e            r_state;
    logic [63:0]       r_cycle;
    logic [NUM_CH-1:0] r_ch_done;
    logic              r_done, r_pass, r_fail, r_tmo;
    logic [FCW-1:0]    r_fail_ch;
    logic [31:0]       r_fail_code;

    logic [NUM_CH-1:0] w_fin_hit, w_fin_good, w_pass_vec, w_fail_vec;
    logic              w_fail_any, w_tmo_hit;
    logic [FCW-1:0]    w_fail_idx;
    logic [31:0]       w_fail_data;
    state_e            w_state_nxt;
    logic [63:0]       w_cycle_nxt;
    logic [NUM_CH-1:0] w_done_nxt;
    logic [FCW-1:0]    w_fail_ch_nxt;
    logic [31:0]       w_fail_code_nxt;

    // Per-channel finish-register decode; only full-word writes count.
    always_comb begin
        w_fin_hit  = '0;
        w_fin_good = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_fin_hit[k]  = (wr_en_i[4*k +: 4] == 4'hF) &&
                            (wr_addr_i[ADDR_W*k +: ADDR_W] == FINISH_ADDR);
            w_fin_good[k] = (wr_data_i[32*k +: 32] == PASS_CODE);
        end
    end

    assign w_pass_vec = w_fin_hit & w_fin_good;
    assign w_fail_vec = w_fin_hit & ~w_fin_good;
    assign w_fail_any = |w_fail_vec;
    assign w_tmo_hit  = TMO_EN && (r_cycle == TMO_LAST);

    // Lowest failing channel wins: scan downward so lower indices overwrite.
    always_comb begin
        w_fail_idx  = '0;
        w_fail_data = 32'h0000_0000;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_fail_idx  = w_fail_vec[k] ? FCW'(k) : w_fail_idx;
            w_fail_data = w_fail_vec[k] ? wr_data_i[32*k +: 32] : w_fail_data;
        end
    end

    // Next-state logic: clear beats everything, then FAIL > PASS > TMO.
    always_comb begin
        w_state_nxt     = r_state;
        w_cycle_nxt     = r_cycle;
        w_done_nxt      = r_ch_done;
        w_fail_ch_nxt   = r_fail_ch;
        w_fail_code_nxt = r_fail_code;
        if (clr_i) begin
            w_state_nxt     = RUN;
            w_cycle_nxt     = 64'd0;
            w_done_nxt      = '0;
            w_fail_ch_nxt   = '0;
            w_fail_code_nxt = 32'h0000_0000;
        end else begin
            case (r_state)
                RUN: begin
                    w_cycle_nxt = r_cycle + 64'd1;
                    w_done_nxt  = r_ch_done | w_pass_vec;
                    if (w_fail_any) begin
                        w_state_nxt     = FAIL;
                        w_fail_ch_nxt   = w_fail_idx;
                        w_fail_code_nxt = w_fail_data;
                    end else if (&w_done_nxt) begin
                        w_state_nxt = PASS;
                    end else if (w_tmo_hit) begin
                        w_state_nxt = TMO;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // State and registered status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= RUN;
            r_cycle     <= 64'd0;
            r_ch_done   <= '0;
            r_fail_ch   <= '0;
            r_fail_code <= 32'h0000_0000;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_tmo       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cycle     <= w_cycle_nxt;
            r_ch_done   <= w_done_nxt;
            r_fail_ch   <= w_fail_ch_nxt;
            r_fail_code <= w_fail_code_nxt;
            r_done      <= (w_state_nxt != RUN);
            r_pass      <= (w_state_nxt == PASS);
            r_fail      <= (w_state_nxt == FAIL);
            r_tmo       <= (w_state_nxt == TMO);
        end
    end

    assign cycle_o     = r_cycle;
    assign ch_done_o   = r_ch_done;
    assign done_o      = r_done;
    assign pass_o      = r_pass;
    assign fail_o      = r_fail;
    assign timeout_o   = r_tmo;
    assign fail_ch_o   = r_fail_ch;
    assign fail_code_o = r_fail_code;

`ifdef TEST_MONITOR_CONSOLE_EN
    logic       w_con_push, w_con_multi, w_con_hit;
    logic [7:0] w_con_byte, w_con_head;
    logic       w_con_full, w_con_empty;
    logic       r_con_drop;

    // Pick the lowest-index console write; any further one this cycle is dropped.
    always_comb begin
        w_con_push  = 1'b0;
        w_con_multi = 1'b0;
        w_con_byte  = 8'h00;
        w_con_hit   = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_con_hit   = wr_en_i[4*k] && (wr_addr_i[ADDR_W*k +: ADDR_W] == CON_ADDR);
            w_con_multi = w_con_multi | (w_con_hit & w_con_push);
            w_con_byte  = (w_con_hit && !w_con_push) ? wr_data_i[32*k +: 8] : w_con_byte;
            w_con_push  = w_con_push | w_con_hit;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (CON_DEPTH)
    ) u_con_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (clr_i),
        .push_i      (w_con_push),
        .push_data_i (w_con_byte),
        .pop_i       (con_ready_i),
        .pop_data_o  (w_con_head),
        .full_o      (w_con_full),
        .empty_o     (w_con_empty)
    );

    // Sticky drop flag: lost same-cycle writes or a push into a full FIFO with no pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_con_drop <= 1'b0;
        end else if (clr_i) begin
            r_con_drop <= 1'b0;
        end else if (w_con_multi || (w_con_push && w_con_full && !con_ready_i)) begin
            r_con_drop <= 1'b1;
        end else begin
            r_con_drop <= r_con_drop;
        end
    end

    assign con_valid_o = !w_con_empty;
    assign con_data_o  = w_con_head;
    assign con_drop_o  = r_con_drop;
`else
    logic w_unused_con_cfg;
    assign w_unused_con_cfg = ^{CON_ADDR, 32'(CON_DEPTH)};
`endif

endmodule

// File: tb/tb_test_monitor.sv
// Directed bench for test_monitor: three instances cover one-channel,
// two-channel and watchdog configurations; console checks when the macro is set.
module tb_test_monitor;
    localparam logic [31:0] FIN = 32'h4000_8000;
    localparam logic [31:0] CON = 32'h4000_8004;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  a_en = 4'h0;  logic [31:0] a_addr = 32'h0; logic [31:0] a_data = 32'h0;
    logic [7:0]  b_en = 8'h0;  logic [63:0] b_addr = 64'h0; logic [63:0] b_data = 64'h0;
    logic [3:0]  c_en = 4'h0;  logic [31:0] c_addr = 32'h0; logic [31:0] c_data = 32'h0;

    logic [63:0] a_cyc, b_cyc, c_cyc;
    logic [0:0]  a_chd; logic [1:0] b_chd; logic [0:0] c_chd;
    logic a_done, a_pass, a_fail, a_tmo, b_done, b_pass, b_fail, b_tmo, c_done, c_pass, c_fail, c_tmo;
    logic [0:0] a_fch, b_fch, c_fch;
    logic [31:0] a_fcode, b_fcode, c_fcode;
`ifdef TEST_MONITOR_CONSOLE_EN
    logic a_rdy = 1'b0; logic a_val; logic [7:0] a_cd; logic a_drop;
    logic b_val, b_drop, c_val, c_drop; logic [7:0] b_cd, c_cd;
`endif

    int n_vec = 0;
    int n_err = 0;

    test_monitor #(.NUM_CH(1), .CON_DEPTH(4)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .wr_en_i(a_en), .wr_addr_i(a_addr), .wr_data_i(a_data),
`ifdef TEST_MONITOR_CONSOLE_EN
        .con_ready_i(a_rdy), .con_valid_o(a_val), .con_data_o(a_cd), .con_drop_o(a_drop),
`endif
        .cycle_o(a_cyc), .ch_done_o(a_chd), .done_o(a_done), .pass_o(a_pass),
        .fail_o(a_fail), .timeout_o(a_tmo), .fail_ch_o(a_fch), .fail_code_o(a_fcode));

    test_monitor #(.NUM_CH(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .wr_en_i(b_en), .wr_addr_i(b_addr), .wr_data_i(b_data),
`ifdef TEST_MONITOR_CONSOLE_EN
        .con_ready_i(1'b0), .con_valid_o(b_val), .con_data_o(b_cd), .con_drop_o(b_drop),
`endif
        .cycle_o(b_cyc), .ch_done_o(b_chd), .done_o(b_done), .pass_o(b_pass),
        .fail_o(b_fail), .timeout_o(b_tmo), .fail_ch_o(b_fch), .fail_code_o(b_fcode));

    test_monitor #(.NUM_CH(1), .TIMEOUT_CYCLES(100)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .wr_en_i(c_en), .wr_addr_i(c_addr), .wr_data_i(c_data),
`ifdef TEST_MONITOR_CONSOLE_EN
        .con_ready_i(1'b0), .con_valid_o(c_val), .con_data_o(c_cd), .con_drop_o(c_drop),
`endif
        .cycle_o(c_cyc), .ch_done_o(c_chd), .done_o(c_done), .pass_o(c_pass),
        .fail_o(c_fail), .timeout_o(c_tmo), .fail_ch_o(c_fch), .fail_code_o(c_fcode));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        a_en = 4'h0; a_addr = 32'h0; a_data = 32'h0;
        b_en = 8'h0; b_addr = 64'h0; b_data = 64'h0;
        c_en = 4'h0; c_addr = 32'h0; c_data = 32'h0;
    endtask

    task automatic restart();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    initial begin
        // Reset values while rst_n is held low
        #12;
        chk("rst_cycle", a_cyc, 64'd0);
        chk("rst_done",  {63'd0, a_done}, 64'd0);
        chk("rst_pass",  {63'd0, a_pass}, 64'd0);
        chk("rst_fail",  {63'd0, a_fail}, 64'd0);
        chk("rst_tmo",   {63'd0, c_tmo}, 64'd0);
        chk("rst_chd",   {62'd0, b_chd}, 64'd0);
        chk("rst_fch",   {63'd0, a_fch}, 64'd0);
        chk("rst_fcode", {32'd0, a_fcode}, 64'd0);
        rst_n = 1'b1;

        // One channel passes at cycle 10
        tick(10);
        chk("a_cyc10", a_cyc, 64'd10);
        a_en = 4'hF; a_addr = FIN; a_data = 32'h777;
        tick(1);
        idle();
        chk("a_pass", {63'd0, a_pass}, 64'd1);
        chk("a_done", {63'd0, a_done}, 64'd1);
        chk("a_chd",  {63'd0, a_chd}, 64'd1);
        chk("a_cyc11", a_cyc, 64'd11);
        tick(3);
        chk("a_cyc_frozen", a_cyc, 64'd11);

        // Fail code capture, then a late pass is ignored
        restart();
        chk("clr_cyc", a_cyc, 64'd0);
        chk("clr_pass", {63'd0, a_pass}, 64'd0);
        a_en = 4'hF; a_addr = FIN; a_data = 32'h123;
        tick(1);
        chk("a_fail", {63'd0, a_fail}, 64'd1);
        chk("a_fcode", {32'd0, a_fcode}, 64'h123);
        chk("a_fch", {63'd0, a_fch}, 64'd0);
        a_data = 32'h777;
        tick(1);
        idle();
        chk("a_fail_hold", {63'd0, a_fail}, 64'd1);
        chk("a_nopass", {63'd0, a_pass}, 64'd0);
        chk("a_fcode_hold", {32'd0, a_fcode}, 64'h123);

        // Clear wins over a same-cycle fail write
        restart();
        tick(4);
        clr = 1'b1; a_en = 4'hF; a_addr = FIN; a_data = 32'h55;
        tick(1);
        clr = 1'b0; idle();
        chk("clrw_fail", {63'd0, a_fail}, 64'd0);
        chk("clrw_done", {63'd0, a_done}, 64'd0);
        chk("clrw_cyc", a_cyc, 64'd0);
        chk("clrw_fcode", {32'd0, a_fcode}, 64'd0);

        // Two channels: ch0 at cycle 5 (repeated), ch1 at cycle 9
        tick(5);
        chk("b_cyc5", b_cyc, 64'd5);
        b_en = 8'h0F; b_addr = {32'h0, FIN}; b_data = {32'h0, 32'h777};
        tick(1);
        chk("b_chd01", {62'd0, b_chd}, 64'd1);
        chk("b_nopass1", {63'd0, b_pass}, 64'd0);
        tick(1);
        idle();
        chk("b_chd01_rep", {62'd0, b_chd}, 64'd1);
        tick(2);
        chk("b_cyc9", b_cyc, 64'd9);
        chk("b_nopass9", {63'd0, b_pass}, 64'd0);
        b_en = 8'hF0; b_addr = {FIN, 32'h0}; b_data = {32'h777, 32'h0};
        tick(1);
        idle();
        chk("b_chd11", {62'd0, b_chd}, 64'd3);
        chk("b_pass", {63'd0, b_pass}, 64'd1);
        chk("b_cyc10", b_cyc, 64'd10);

        // Simultaneous fails: lowest channel wins
        restart();
        b_en = 8'hFF; b_addr = {FIN, FIN}; b_data = {32'h6, 32'h5};
        tick(1);
        idle();
        chk("b_fail2", {63'd0, b_fail}, 64'd1);
        chk("b_fch0", {63'd0, b_fch}, 64'd0);
        chk("b_fcode5", {32'd0, b_fcode}, 64'd5);
        restart();
        b_en = 8'hF0; b_addr = {FIN, 32'h0}; b_data = {32'h9, 32'h0};
        tick(1);
        idle();
        chk("b_fch1", {63'd0, b_fch}, 64'd1);
        chk("b_fcode9", {32'd0, b_fcode}, 64'd9);

        // Watchdog: partial enable ignored, TMO when cycle_o is 99
        restart();
        c_en = 4'h3; c_addr = FIN; c_data = 32'h123;
        tick(1);
        idle();
        chk("c_partial_done", {63'd0, c_done}, 64'd0);
        chk("c_partial_fail", {63'd0, c_fail}, 64'd0);
        tick(98);
        chk("c_cyc99", c_cyc, 64'd99);
        chk("c_notmo99", {63'd0, c_tmo}, 64'd0);
        tick(1);
        chk("c_tmo", {63'd0, c_tmo}, 64'd1);
        chk("c_tmo_done", {63'd0, c_done}, 64'd1);
        chk("c_cyc100", c_cyc, 64'd100);
        tick(2);
        chk("c_cyc_frozen", c_cyc, 64'd100);
        restart();
        tick(99);
        c_en = 4'hF; c_addr = FIN; c_data = 32'h777;
        tick(1);
        idle();
        chk("c_pass_over_tmo", {63'd0, c_pass}, 64'd1);
        chk("c_no_tmo", {63'd0, c_tmo}, 64'd0);

        // Asynchronous reset takes effect without a clock edge
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_c_pass", {63'd0, c_pass}, 64'd0);
        chk("arst_c_cyc", c_cyc, 64'd0);
        chk("arst_c_done", {63'd0, c_done}, 64'd0);
        #1;
        rst_n = 1'b1;
        tick(1);
        chk("arst_resume", c_cyc, 64'd1);

`ifdef TEST_MONITOR_CONSOLE_EN
        // Console: depth 4, stalled sink, push "ABCDE"
        restart();
        a_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_en = 4'h1; a_addr = CON; a_data = 32'h41 + 32'(i);
            tick(1);
            if (i == 0) begin
                chk("con_valid1", {63'd0, a_val}, 64'd1);
                chk("con_head1", {56'd0, a_cd}, 64'h41);
            end
            if (i == 3) chk("con_nodrop4", {63'd0, a_drop}, 64'd0);
        end
        idle();
        chk("con_drop", {63'd0, a_drop}, 64'd1);
        chk("con_stable", {56'd0, a_cd}, 64'h41);
        chk("con_no_finish", {63'd0, a_done}, 64'd0);
        a_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("con_valid", {63'd0, a_val}, 64'd1);
            chk("con_byte", {56'd0, a_cd}, 64'h41 + 64'(i));
            tick(1);
        end
        chk("con_empty", {63'd0, a_val}, 64'd0);
        chk("con_drop_sticky", {63'd0, a_drop}, 64'd1);
        restart();
        chk("con_drop_clr", {63'd0, a_drop}, 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
